// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg: shared state encoding and overflow helper for the adder arbiter
package adder_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic y_msb);
        return (a_msb == b_msb) && (y_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_arbiter_adder.sv
// adder_arbiter_adder: the single shared combinational adder, result modulo 2^WIDTH
module adder_arbiter_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y
);

    assign Y = A + B;

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one adder among NUM_REQ requesters with a registered response
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_y,
    output logic                     rsp_ovf
);

    state_t           state, state_next;
    logic [ID_W-1:0]  last_grant, grant;
    logic             found, accept;
    logic [WIDTH-1:0] a_sel, b_sel, sum;

    // Requesters above last_grant win first; otherwise the search wraps to the lowest index.
    always_comb begin
        grant = last_grant;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            if (!found && req_valid[i] && i > int'(last_grant)) begin
                grant = ID_W'(i);
                found = 1'b1;
            end
        for (int i = 0; i < NUM_REQ; i++)
            if (!found && req_valid[i]) begin
                grant = ID_W'(i);
                found = 1'b1;
            end
    end

    assign accept    = ((state == ST_IDLE) || rsp_ready) && |req_valid;
    assign req_ready = accept ? (NUM_REQ'(1) << grant) : '0;
    assign a_sel     = req_a[int'(grant)*WIDTH +: WIDTH];
    assign b_sel     = req_b[int'(grant)*WIDTH +: WIDTH];
    assign rsp_valid = (state == ST_RESP);

    adder_arbiter_adder #(.WIDTH(WIDTH)) u_adder (
        .A(a_sel),
        .B(b_sel),
        .Y(sum)
    );

    always_comb begin
        state_next = state;
        if (accept)
            state_next = ST_RESP;
        else if (rsp_ready)
            state_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_y      <= '0;
            rsp_id     <= '0;
            rsp_ovf    <= 1'b0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            rsp_y      <= sum;
            rsp_id     <= grant;
            rsp_ovf    <= add_ovf(a_sel[WIDTH-1], b_sel[WIDTH-1], sum[WIDTH-1]);
            last_grant <= grant;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed checks of arbitration, handshake, arithmetic and reset
module tb_adder_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_y;
    logic         rsp_ovf;
    int           total = 0;
    int           bad = 0;

    adder_arbiter #(.WIDTH(32), .NUM_REQ(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_ovf(rsp_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step();
        total += 5;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
        if (rsp_y !== 32'h0) begin bad++; $display("FAIL reset_y got=%h exp=0", rsp_y); end
        if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
        if (rsp_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", rsp_ovf); end
        if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        set_op(0, 32'd10, 32'd20);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL basic_ready got=%b exp=0001", req_ready); end
        step();
        req_valid = 4'b0000;
        total += 4;
        if (rsp_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", rsp_valid); end
        if (rsp_id !== 2'd0) begin bad++; $display("FAIL basic_id got=%0d exp=0", rsp_id); end
        if (rsp_y !== 32'd30) begin bad++; $display("FAIL basic_y got=%h exp=%h", rsp_y, 32'd30); end
        if (rsp_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", rsp_ovf); end
        step();
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 32'(i * 100), 32'(i));
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (req_ready !== (4'b0001 << (k % 4))) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, 4'b0001 << (k % 4)); end
            step();
            total += 3;
            if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%b exp=1", k, rsp_valid); end
            if (rsp_id !== 2'(k % 4)) begin bad++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", k, rsp_id, k % 4); end
            if (rsp_y !== 32'((k % 4) * 101)) begin bad++; $display("FAIL rr_y[%0d] got=%0d exp=%0d", k, rsp_y, (k % 4) * 101); end
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_backpressure();
        set_op(1, -32'sd10, -32'sd20);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        set_op(0, 32'd5, 32'd6);
        req_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            total += 5;
            if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, rsp_valid); end
            if (rsp_y !== 32'hFFFFFFE2) begin bad++; $display("FAIL bp_y[%0d] got=%h exp=ffffffe2", c, rsp_y); end
            if (rsp_ovf !== 1'b0) begin bad++; $display("FAIL bp_ovf[%0d] got=%b exp=0", c, rsp_ovf); end
            if (rsp_id !== 2'd1) begin bad++; $display("FAIL bp_id[%0d] got=%0d exp=1", c, rsp_id); end
            if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, req_ready); end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_release got=%b exp=0001", req_ready); end
        step();
        req_valid = 4'b0000;
        total += 2;
        if (rsp_id !== 2'd0) begin bad++; $display("FAIL bp_next_id got=%0d exp=0", rsp_id); end
        if (rsp_y !== 32'd11) begin bad++; $display("FAIL bp_next_y got=%0d exp=11", rsp_y); end
        step();
    endtask

    task automatic test_arith();
        logic [31:0] va [3] = '{32'h7FFFFFFF, 32'h80000000, 32'd15};
        logic [31:0] vb [3] = '{32'h00000001, 32'h80000000, -32'sd5};
        logic [31:0] vy [3] = '{32'h80000000, 32'h00000000, 32'd10};
        logic        vo [3] = '{1'b1, 1'b1, 1'b0};
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_op(2, va[k], vb[k]);
            req_valid = 4'b0100;
            step();
            req_valid = 4'b0000;
            total += 3;
            if (rsp_y !== vy[k]) begin bad++; $display("FAIL arith_y[%0d] got=%h exp=%h", k, rsp_y, vy[k]); end
            if (rsp_ovf !== vo[k]) begin bad++; $display("FAIL arith_ovf[%0d] got=%b exp=%b", k, rsp_ovf, vo[k]); end
            if (rsp_id !== 2'd2) begin bad++; $display("FAIL arith_id[%0d] got=%0d exp=2", k, rsp_id); end
            step();
        end
    endtask

    task automatic test_wrap();
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        step();
        set_op(3, 32'd7, 32'd8);
        set_op(0, 32'd1, 32'd2);
        req_valid = 4'b1001;
        #1;
        total++;
        if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_ready3 got=%b exp=1000", req_ready); end
        step();
        total += 3;
        if (rsp_id !== 2'd3) begin bad++; $display("FAIL wrap_id3 got=%0d exp=3", rsp_id); end
        if (rsp_y !== 32'd15) begin bad++; $display("FAIL wrap_y3 got=%0d exp=15", rsp_y); end
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_ready0 got=%b exp=0001", req_ready); end
        step();
        req_valid = 4'b0000;
        total += 2;
        if (rsp_id !== 2'd0) begin bad++; $display("FAIL wrap_id0 got=%0d exp=0", rsp_id); end
        if (rsp_y !== 32'd3) begin bad++; $display("FAIL wrap_y0 got=%0d exp=3", rsp_y); end
        step();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        step();
        rsp_ready = 1'b0;
        req_valid = 4'b0000;
        total++;
        if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", rsp_valid); end
        rst = 1'b1;
        #1;
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_async got=%b exp=0", rsp_valid); end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        step();
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL rstmid_grant got=%b exp=0001", req_ready); end
        step();
        req_valid = 4'b0000;
        total += 2;
        if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rstmid_valid got=%b exp=1", rsp_valid); end
        if (rsp_id !== 2'd0) begin bad++; $display("FAIL rstmid_id got=%0d exp=0", rsp_id); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_arith();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
